// File: rtl/cordic_pkg.sv
// cordic_pkg: shared constants and types for the hyperbolic CORDIC wrapper and its downstream stages
package cordic_pkg;
  localparam int IEEE_W = 32;
  localparam logic [1:0] TAG_EPX = 2'd0;
  localparam logic [1:0] TAG_SINHX = 2'd1;
  localparam logic [1:0] TAG_COSHX = 2'd2;
  localparam logic [IEEE_W-1:0] COEFF_2P16 = 32'h47800000;
  typedef struct packed {
    logic [IEEE_W-1:0] coshx;
    logic [IEEE_W-1:0] sinhx;
    logic [IEEE_W-1:0] epx;
  } triple_t;
  function automatic logic [IEEE_W-1:0] pick_word(triple_t t, logic [1:0] idx);
    return idx == TAG_COSHX ? t.coshx : idx == TAG_SINHX ? t.sinhx : t.epx;
  endfunction
endpackage

// File: rtl/triple_fifo.sv
// triple_fifo: pointer/level FIFO of DEPTH result triples; a pop frees a slot for a same-cycle push
module triple_fifo
  import cordic_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_push,
  input  logic          i_pop,
  input  triple_t       i_wdata,
  output triple_t       o_rdata,
  output logic          o_full,
  output logic          o_empty,
  output logic [LW-1:0] o_level
);
  triple_t r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [LW-1:0] r_level;
  logic w_push, w_pop;
  assign w_pop = i_pop & ~o_empty;
  assign w_push = i_push & (~o_full | w_pop);
  assign o_full = r_level == LW'(DEPTH);
  assign o_empty = r_level == '0;
  assign o_level = r_level;
  assign o_rdata = r_mem[r_rd_ptr];
  // storage is deliberately not reset; level gates everything read from it
  always_ff @(posedge clk)
    if (w_push) r_mem[r_wr_ptr] <= i_wdata;
  // pointers wrap naturally at a power-of-two depth; level tells full from empty
  always_ff @(posedge clk)
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      r_level <= r_level + LW'(w_push) - LW'(w_pop);
    end
endmodule

// File: rtl/cordic_result_serializer.sv
// cordic_result_serializer: buffers result triples and streams them as tagged 32-bit words
module cordic_result_serializer
  import cordic_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int LW = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [IEEE_W-1:0] ieee_epx,
  input  logic [IEEE_W-1:0] ieee_sinhx,
  input  logic [IEEE_W-1:0] ieee_coshx,
  input  logic              valid,
  output logic [IEEE_W-1:0] output_z,
  output logic [1:0]        output_z_tag,
  output logic              output_z_stb,
  input  logic              output_z_ack,
  output logic [LW-1:0]     level,
  output logic              overflow
);
  logic r_valid_d, r_overflow;
  logic [1:0] r_word_idx;
  logic w_push, w_xfer, w_last, w_full, w_empty;
  triple_t w_rdata;
  assign w_push = valid & ~r_valid_d;
  assign output_z_stb = level != '0;
  assign w_xfer = output_z_stb & output_z_ack;
  assign w_last = w_xfer & (r_word_idx == TAG_COSHX);
  assign output_z = pick_word(w_rdata, r_word_idx);
  assign output_z_tag = r_word_idx;
  assign overflow = r_overflow;
  triple_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .i_push (w_push),
    .i_pop  (w_last),
    .i_wdata('{coshx: ieee_coshx, sinhx: ieee_sinhx, epx: ieee_epx}),
    .o_rdata(w_rdata),
    .o_full (w_full),
    .o_empty(w_empty),
    .o_level(level)
  );
  // edge detect starts high so a valid held through reset is not captured; word index walks epx, sinhx, coshx
  always_ff @(posedge clk)
    if (rst) begin
      r_valid_d <= 1'b1;
      r_word_idx <= TAG_EPX;
      r_overflow <= 1'b0;
    end else begin
      r_valid_d <= valid;
      if (w_xfer) r_word_idx <= w_last ? TAG_EPX : r_word_idx + 1'b1;
      if (w_push & w_full & ~w_last) r_overflow <= 1'b1;
    end
  logic w_unused;
  assign w_unused = w_empty;
endmodule

// File: tb/tb_cordic_result_serializer.sv
// tb_cordic_result_serializer: scenario tasks checked against a word-queue reference model
module tb_cordic_result_serializer;
  import cordic_pkg::*;
  localparam int DEPTH = 4;
  logic clk = 0, rst = 1, valid = 0, output_z_ack = 0;
  logic [31:0] ieee_epx = 0, ieee_sinhx = 0, ieee_coshx = 0;
  logic [31:0] output_z;
  logic [1:0] output_z_tag;
  logic output_z_stb, overflow;
  logic [2:0] level;
  int checks = 0, errors = 0;
  logic [33:0] mq[$];
  logic [33:0] got[$];
  logic [33:0] want[$];
  logic m_vd = 1, m_ovf = 0;

  cordic_result_serializer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .ieee_epx(ieee_epx), .ieee_sinhx(ieee_sinhx), .ieee_coshx(ieee_coshx),
    .valid(valid), .output_z(output_z), .output_z_tag(output_z_tag), .output_z_stb(output_z_stb),
    .output_z_ack(output_z_ack), .level(level), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic cycle();
    int n = mq.size();
    bit xfer = output_z_ack && n > 0;
    bit last = xfer && (n % 3 == 1);
    bit push = valid && !m_vd;
    bit acc = push && (((n + 2) / 3) < DEPTH || last);
    logic [31:0] e = ieee_epx, s = ieee_sinhx, c = ieee_coshx;
    if (xfer && !rst) got.push_back({output_z_tag, output_z});
    @(posedge clk);
    if (rst) begin
      mq.delete();
      m_ovf = 0;
      m_vd = 1;
    end else begin
      if (push && !acc) m_ovf = 1;
      if (xfer) void'(mq.pop_front());
      if (acc) begin
        mq.push_back({2'd0, e});
        mq.push_back({2'd1, s});
        mq.push_back({2'd2, c});
      end
      m_vd = valid;
    end
    #1;
  endtask

  function automatic logic [38:0] exp_v();
    int n = mq.size();
    return {n != 0, n != 0 ? mq[0][33:32] : 2'd0, 3'((n + 2) / 3), m_ovf, n != 0 ? mq[0][31:0] : 32'd0};
  endfunction

  function automatic logic [38:0] dut_v();
    return {output_z_stb, output_z_tag, level, overflow, output_z_stb ? output_z : 32'd0};
  endfunction

  task automatic add_want(logic [31:0] e, logic [31:0] s, logic [31:0] c);
    want.push_back({2'd0, e});
    want.push_back({2'd1, s});
    want.push_back({2'd2, c});
  endtask

  task automatic set_data(logic [31:0] e, logic [31:0] s, logic [31:0] c);
    ieee_epx = e;
    ieee_sinhx = s;
    ieee_coshx = c;
  endtask

  task automatic test_reset();
    rst = 1;
    valid = 1;
    cycle();
    cycle();
    checks++;
    if ({output_z_stb, level, overflow, output_z_tag} !== 7'd0) begin
      errors++;
      $display("FAIL reset stb/level/ovf/tag got %b exp 0", {output_z_stb, level, overflow, output_z_tag});
    end
    rst = 0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      checks++;
      if (level !== 3'd0) begin
        errors++;
        $display("FAIL reset_held_valid level got %0d exp 0", level);
      end
    end
    valid = 0;
    cycle();
  endtask

  task automatic test_single();
    got.delete();
    want.delete();
    set_data(32'h402DF854, 32'h3F966CFE, 32'h3FC583AB);
    add_want(32'h402DF854, 32'h3F966CFE, 32'h3FC583AB);
    output_z_ack = 1;
    for (int i = 0; i < 8; i++) begin
      valid = i < 3;
      cycle();
      checks++;
      if (dut_v() !== exp_v()) begin
        errors++;
        $display("FAIL single cyc%0d got %h exp %h", i, dut_v(), exp_v());
      end
    end
    checks++;
    if (got.size() != 3 || got != want) begin
      errors++;
      $display("FAIL single_words got %0d words exp 3 (first got %h exp %h)", got.size(), got.size() ? got[0] : 34'd0, want[0]);
    end
  endtask

  task automatic test_backpressure();
    bit pat[6] = '{0, 1, 0, 0, 1, 1};
    logic [33:0] prev;
    bit hold;
    got.delete();
    want.delete();
    add_want(32'h402DF854, 32'h3F966CFE, 32'h3FC583AB);
    output_z_ack = 0;
    valid = 1;
    cycle();
    valid = 0;
    for (int i = 0; i < 6; i++) begin
      output_z_ack = pat[i];
      hold = output_z_stb && !output_z_ack;
      prev = {output_z_tag, output_z};
      cycle();
      checks++;
      if (dut_v() !== exp_v() || (hold && {output_z_tag, output_z} !== prev)) begin
        errors++;
        $display("FAIL backpressure cyc%0d got %h exp %h prev %h", i, dut_v(), exp_v(), prev);
      end
    end
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL backpressure_words got %0d words exp %0d", got.size(), want.size());
    end
  endtask

  task automatic test_overflow();
    output_z_ack = 0;
    got.delete();
    want.delete();
    for (int i = 0; i < 5; i++) begin
      set_data(32'h3F800000 + i, 32'h40000000 + i, 32'h40400000 + i);
      if (i < 4) add_want(32'h3F800000 + i, 32'h40000000 + i, 32'h40400000 + i);
      valid = 1;
      cycle();
      valid = 0;
      cycle();
      checks++;
      if (dut_v() !== exp_v()) begin
        errors++;
        $display("FAIL fill push%0d got %h exp %h", i, dut_v(), exp_v());
      end
    end
    checks++;
    if (level !== 3'd4 || overflow !== 1'b1) begin
      errors++;
      $display("FAIL overflow level/ovf got %0d/%b exp 4/1", level, overflow);
    end
    output_z_ack = 1;
    for (int i = 0; i < 14; i++) begin
      cycle();
      checks++;
      if (dut_v() !== exp_v()) begin
        errors++;
        $display("FAIL overflow_drain cyc%0d got %h exp %h", i, dut_v(), exp_v());
      end
    end
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL overflow_words got %0d words exp 12", got.size());
    end
    rst = 1;
    cycle();
    rst = 0;
  endtask

  task automatic test_full_coincident();
    output_z_ack = 0;
    valid = 0;
    got.delete();
    want.delete();
    cycle();
    for (int i = 0; i < 8; i++)
      add_want(32'h3F000000 + i, 32'h41000000 + i, 32'h42000000 + i);
    for (int i = 0; i < 4; i++) begin
      set_data(32'h3F000000 + i, 32'h41000000 + i, 32'h42000000 + i);
      valid = 1;
      cycle();
      valid = 0;
      cycle();
    end
    output_z_ack = 1;
    for (int r = 0; r < 4; r++) begin
      cycle();
      cycle();
      set_data(32'h3F000000 + 4 + r, 32'h41000000 + 4 + r, 32'h42000000 + 4 + r);
      valid = 1;
      cycle();
      valid = 0;
      checks++;
      if (level !== 3'd4 || overflow !== 1'b0 || dut_v() !== exp_v()) begin
        errors++;
        $display("FAIL coincident round%0d level %0d ovf %b got %h exp %h", r, level, overflow, dut_v(), exp_v());
      end
    end
    for (int i = 0; i < 14; i++) begin
      cycle();
      checks++;
      if (dut_v() !== exp_v()) begin
        errors++;
        $display("FAIL coincident_drain cyc%0d got %h exp %h", i, dut_v(), exp_v());
      end
    end
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL coincident_words got %0d words exp 24", got.size());
    end
  endtask

  task automatic test_reset_mid();
    output_z_ack = 0;
    set_data(32'h11111111, 32'h22222222, 32'h33333333);
    valid = 1;
    cycle();
    output_z_ack = 1;
    cycle();
    output_z_ack = 0;
    rst = 1;
    cycle();
    rst = 0;
    checks++;
    if (output_z_stb !== 1'b0 || level !== 3'd0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid stb/level/ovf got %b/%0d/%b exp 0/0/0", output_z_stb, level, overflow);
    end
    for (int i = 0; i < 3; i++) begin
      cycle();
      checks++;
      if (dut_v() !== exp_v()) begin
        errors++;
        $display("FAIL reset_mid_hold cyc%0d got %h exp %h", i, dut_v(), exp_v());
      end
    end
    valid = 0;
    cycle();
    set_data(32'h44444444, 32'h55555555, 32'h66666666);
    valid = 1;
    cycle();
    valid = 0;
    checks++;
    if (level !== 3'd1 || output_z !== 32'h44444444 || output_z_tag !== 2'd0) begin
      errors++;
      $display("FAIL reset_mid_restart level %0d z %h tag %0d exp 1 44444444 0", level, output_z, output_z_tag);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(0, 99) == 0);
      valid = ($urandom_range(0, 2) == 0) ? ~valid : valid;
      output_z_ack = ($urandom_range(0, 3) != 0) ? (i % 200 < 120 ? 1'b0 : 1'b1) : $urandom_range(0, 1);
      set_data($urandom, $urandom, $urandom);
      cycle();
      checks++;
      if (dut_v() !== exp_v()) begin
        errors++;
        $display("FAIL random cyc%0d got %h exp %h", i, dut_v(), exp_v());
      end
    end
    rst = 0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_overflow();
    test_full_coincident();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
